// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types consumed by the load/store unit.
package rv32i;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    RAM_MASK_B = 2'd0,
    RAM_MASK_H = 2'd1,
    RAM_MASK_W = 2'd2
  } ram_mask_e;

  typedef enum logic [2:0] {
    REG_MASK_B  = 3'd0,
    REG_MASK_BX = 3'd1,
    REG_MASK_H  = 3'd2,
    REG_MASK_HX = 3'd3,
    REG_MASK_W  = 3'd4
  } reg_mask_e;

endpackage

// File: rtl/rv32i_lsu_if.sv
// Request, data-RAM bus and response signals of the LSU; slave = LSU side.
interface rv32i_lsu_if;
  import rv32i::*;

  logic        req_valid;
  logic        req_ready;
  mem_op_e     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  ram_mask_e   req_ram_mask;
  reg_mask_e   req_reg_mask;

  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misaligned;
  logic        rsp_timeout;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_ram_mask, req_reg_mask,
    output req_ready,
    output mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output rsp_valid, rsp_rdata, rsp_misaligned, rsp_timeout
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_ram_mask, req_reg_mask,
    input  req_ready,
    input  mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  rsp_valid, rsp_rdata, rsp_misaligned, rsp_timeout
  );

endinterface

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: lane alignment, byte enables, load extension over a handshaked RAM bus.
// Optional bus timeout enabled by defining RV32I_LSU_TIMEOUT_EN.
module rv32i_lsu
  import rv32i::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  rv32i_lsu_if.slave  bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_param_chk
    $error("rv32i_lsu: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_e;

  state_e      state_q;
  logic        is_store_q;
  logic [1:0]  k_q;
  reg_mask_e   reg_mask_q;

  logic        mem_valid_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;

  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_mis_q;

`ifdef RV32I_LSU_TIMEOUT_EN
  localparam int TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLoad = TmoW'(TIMEOUT_CYCLES);
  logic [TmoW-1:0] tmo_q;
  logic            rsp_to_q;
  logic            tmo_expire;
  assign tmo_expire = (tmo_q == TmoW'(1));
`endif

  // Request decode: lane enables, replicated store data, alignment judged by access size
  logic        misaligned;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  always_comb begin
    misaligned = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = bus.req_wdata;
    case (bus.req_ram_mask)
      RAM_MASK_B: begin
        be_d    = 4'b0001 << bus.req_addr[1:0];
        wdata_d = {4{bus.req_wdata[7:0]}};
      end
      RAM_MASK_H: begin
        misaligned = bus.req_addr[0];
        be_d       = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d    = {2{bus.req_wdata[15:0]}};
      end
      default: misaligned = |bus.req_addr[1:0];
    endcase
  end

  logic [31:0] rd_shift;
  logic [31:0] load_ext;

  always_comb begin
    rd_shift = bus.mem_rdata >> {k_q, 3'b000};
    load_ext = rd_shift;
    case (reg_mask_q)
      REG_MASK_B:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      REG_MASK_BX: load_ext = {24'h0, rd_shift[7:0]};
      REG_MASK_H:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      REG_MASK_HX: load_ext = {16'h0, rd_shift[15:0]};
      default:     load_ext = rd_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      is_store_q  <= 1'b0;
      k_q         <= 2'b00;
      reg_mask_q  <= REG_MASK_W;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_mis_q   <= 1'b0;
`ifdef RV32I_LSU_TIMEOUT_EN
      tmo_q       <= '0;
      rsp_to_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            is_store_q <= (bus.req_op == MEM_STORE);
            k_q        <= bus.req_addr[1:0];
            reg_mask_q <= bus.req_reg_mask;
            if (misaligned) begin
              // No bus access: answer straight away
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_mis_q   <= 1'b1;
              rsp_rdata_q <= 32'h0;
            end else begin
              state_q     <= S_REQ;
              mem_valid_q <= 1'b1;
              mem_we_q    <= (bus.req_op == MEM_STORE);
              mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
`ifdef RV32I_LSU_TIMEOUT_EN
              tmo_q       <= TmoLoad;
`endif
            end
          end
        end
        S_REQ: begin
          if (bus.mem_ready) begin
            mem_valid_q <= 1'b0;
            if (is_store_q) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= 32'h0;
            end else begin
              state_q <= S_WAIT;
`ifdef RV32I_LSU_TIMEOUT_EN
              tmo_q   <= TmoLoad;
`endif
            end
          end
`ifdef RV32I_LSU_TIMEOUT_EN
          else if (tmo_expire) begin
            mem_valid_q <= 1'b0;
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_to_q    <= 1'b1;
            rsp_rdata_q <= 32'h0;
          end else begin
            tmo_q <= tmo_q - TmoW'(1);
          end
`endif
        end
        S_WAIT: begin
          if (bus.mem_rvalid) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_ext;
          end
`ifdef RV32I_LSU_TIMEOUT_EN
          else if (tmo_expire) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_to_q    <= 1'b1;
            rsp_rdata_q <= 32'h0;
          end else begin
            tmo_q <= tmo_q - TmoW'(1);
          end
`endif
        end
        default: begin
          // RESP: single-cycle pulse, then reopen for requests
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_mis_q   <= 1'b0;
          rsp_rdata_q <= 32'h0;
`ifdef RV32I_LSU_TIMEOUT_EN
          rsp_to_q    <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign bus.req_ready      = (state_q == S_IDLE);
  assign bus.mem_valid      = mem_valid_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_be         = mem_be_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_misaligned = rsp_mis_q;
`ifdef RV32I_LSU_TIMEOUT_EN
  assign bus.rsp_timeout    = rsp_to_q;
`else
  assign bus.rsp_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_lsu.sv
// Self-checking bench for rv32i_lsu: directed vectors plus randomized traffic against an arithmetic model.
module tb_rv32i_lsu;
  import rv32i::*;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rv32i_lsu_if bus ();

  rv32i_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic ref_mis(ram_mask_e m, logic [31:0] a);
    if (m == RAM_MASK_H) return (a % 2) != 0;
    if (m == RAM_MASK_B) return 1'b0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [3:0] ref_be(ram_mask_e m, logic [31:0] a);
    int k;
    k = int'(a % 4);
    if (m == RAM_MASK_B) return 4'(1 << k);
    if (m == RAM_MASK_H) return 4'(3 << ((k / 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(ram_mask_e m, logic [31:0] d);
    if (m == RAM_MASK_B) return (d % 256) * 32'h0101_0101;
    if (m == RAM_MASK_H) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(reg_mask_e r, logic [31:0] w, logic [31:0] a);
    logic [31:0] v, b, h;
    v = w >> (8 * (a % 4));
    b = v % 256;
    h = v % 65536;
    case (r)
      REG_MASK_B:  return (b >= 128) ? b - 32'd256 : b;
      REG_MASK_BX: return b;
      REG_MASK_H:  return (h >= 32768) ? h - 32'd65536 : h;
      REG_MASK_HX: return h;
      default:     return w >> (8 * (a % 4));
    endcase
  endfunction

  // ---------------- generic transaction ----------------
  task automatic do_txn(input string nm, input logic st, input logic [31:0] addr,
                        input logic [31:0] wd, input ram_mask_e rm, input reg_mask_e gm,
                        input int rdy_dly, input int rv_dly, input logic [31:0] rdata);
    int n;
    logic [70:0] exp_bus;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_wait got %b need 1", nm, bus.req_ready);
    end
    bus.req_valid    = 1'b1;
    bus.req_op       = st ? MEM_STORE : MEM_LOAD;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_ram_mask = rm;
    bus.req_reg_mask = gm;
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    if (ref_mis(rm, addr)) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_misaligned, bus.rsp_rdata, bus.mem_valid, bus.req_ready} !== {2'b11, 32'h0, 2'b00}) begin
        errors++; $display("FAIL %s mis_rsp got v=%b m=%b d=%h mv=%b rdy=%b need 1 1 0 0 0", nm,
                           bus.rsp_valid, bus.rsp_misaligned, bus.rsp_rdata, bus.mem_valid, bus.req_ready);
      end
    end else begin
      exp_bus = {1'b1, st, addr - (addr % 4), ref_be(rm, addr), ref_wdata(rm, wd)};
      for (int i = 0; i <= rdy_dly; i++) begin
        checks++;
        if ({bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== exp_bus ||
            bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
          errors++; $display("FAIL %s req_cyc%0d got v=%b we=%b a=%h be=%b d=%h rdy=%b rv=%b need %h rdy=0 rv=0",
                             nm, i, bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
                             bus.req_ready, bus.rsp_valid, exp_bus);
        end
        bus.mem_ready = (i == rdy_dly);
        tick();
      end
      bus.mem_ready = 1'b0;
      if (!st) begin
        for (int i = 0; i <= rv_dly; i++) begin
          checks++;
          if ({bus.mem_valid, bus.rsp_valid, bus.req_ready} !== 3'b000) begin
            errors++; $display("FAIL %s wait_cyc%0d got mv=%b rv=%b rdy=%b need 0 0 0",
                               nm, i, bus.mem_valid, bus.rsp_valid, bus.req_ready);
          end
          bus.mem_rvalid = (i == rv_dly);
          bus.mem_rdata  = (i == rv_dly) ? rdata : $urandom;
          tick();
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = $urandom;
      end
      checks++;
      if ({bus.rsp_valid, bus.rsp_misaligned, bus.rsp_timeout, bus.mem_valid} !== 4'b1000 ||
          bus.rsp_rdata !== (st ? 32'h0 : ref_load(gm, rdata, addr))) begin
        errors++; $display("FAIL %s rsp got v=%b m=%b t=%b mv=%b d=%h need 1 0 0 0 d=%h", nm,
                           bus.rsp_valid, bus.rsp_misaligned, bus.rsp_timeout, bus.mem_valid,
                           bus.rsp_rdata, st ? 32'h0 : ref_load(gm, rdata, addr));
      end
    end
    tick();
    checks++;
    if ({bus.rsp_valid, bus.req_ready, bus.mem_valid} !== 3'b010) begin
      errors++; $display("FAIL %s after_rsp got rv=%b rdy=%b mv=%b need 0 1 0", nm,
                         bus.rsp_valid, bus.req_ready, bus.mem_valid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = MEM_LOAD; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_ram_mask = RAM_MASK_W; bus.req_reg_mask = REG_MASK_W;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    tick(); tick();
    checks++;
    if ({bus.req_ready, bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
         bus.rsp_valid, bus.rsp_rdata, bus.rsp_misaligned, bus.rsp_timeout} !== {1'b1, 105'h0}) begin
      errors++; $display("FAIL reset_vals got rdy=%b mv=%b we=%b a=%h be=%b wd=%h rv=%b rd=%h m=%b t=%b need rdy=1 rest 0",
                         bus.req_ready, bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
                         bus.rsp_valid, bus.rsp_rdata, bus.rsp_misaligned, bus.rsp_timeout);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_store_byte();
    do_txn("sb_1003", 1'b1, 32'h0000_1003, 32'hAABB_CCDD, RAM_MASK_B, REG_MASK_W, 0, 0, 32'h0);
  endtask

  task automatic test_load_half();
    do_txn("lh_2002", 1'b0, 32'h0000_2002, 32'h0, RAM_MASK_H, REG_MASK_H,  0, 0, 32'h8001_1234);
    do_txn("lhu_2002", 1'b0, 32'h0000_2002, 32'h0, RAM_MASK_H, REG_MASK_HX, 0, 0, 32'h8001_1234);
  endtask

  task automatic test_misaligned();
    do_txn("lw_3001", 1'b0, 32'h0000_3001, 32'h0, RAM_MASK_W, REG_MASK_W, 0, 0, 32'h0);
    do_txn("sh_3003", 1'b1, 32'h0000_3003, 32'h1234_5678, RAM_MASK_H, REG_MASK_W, 0, 0, 32'h0);
  endtask

  task automatic test_stall();
    do_txn("sw_stall", 1'b1, 32'h0000_4000, 32'hCAFE_F00D, RAM_MASK_W, REG_MASK_W, 3, 0, 32'h0);
  endtask

  task automatic test_reset_mid_wait();
    bus.req_valid = 1'b1; bus.req_op = MEM_LOAD; bus.req_addr = 32'h0000_5001;
    bus.req_ram_mask = RAM_MASK_B; bus.req_reg_mask = REG_MASK_B;
    tick();
    bus.req_valid = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({bus.mem_valid, bus.req_ready, bus.rsp_valid} !== 3'b010) begin
      errors++; $display("FAIL rst_wait got mv=%b rdy=%b rv=%b need 0 1 0", bus.mem_valid, bus.req_ready, bus.rsp_valid);
    end
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    tick();
    bus.mem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.req_ready, bus.mem_valid} !== 3'b010) begin
        errors++; $display("FAIL late_rvalid%0d got rv=%b rdy=%b mv=%b need 0 1 0", i,
                           bus.rsp_valid, bus.req_ready, bus.mem_valid);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    do_txn("b2b_sw", 1'b1, 32'h0000_0100, 32'h0102_0304, RAM_MASK_W, REG_MASK_W, 0, 0, 32'h0);
    do_txn("b2b_lbu", 1'b0, 32'h0000_0101, 32'h0, RAM_MASK_B, REG_MASK_BX, 0, 0, 32'h0102_8304);
    do_txn("b2b_lb", 1'b0, 32'h0000_0101, 32'h0, RAM_MASK_B, REG_MASK_B, 0, 0, 32'h0102_8304);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      ram_mask_e   rm;
      a  = $urandom;
      rm = ram_mask_e'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) a = a & ~((rm == RAM_MASK_W) ? 32'h3 : (rm == RAM_MASK_H) ? 32'h1 : 32'h0);
      do_txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), a, $urandom, rm,
             reg_mask_e'($urandom_range(0, 4)), $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
    end
  endtask

`ifdef RV32I_LSU_TIMEOUT_EN
  task automatic test_timeout();
    bus.req_valid = 1'b1; bus.req_op = MEM_LOAD; bus.req_addr = 32'h0000_6000;
    bus.req_ram_mask = RAM_MASK_W; bus.req_reg_mask = REG_MASK_W;
    tick();
    bus.req_valid = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        errors++; $display("FAIL tmo_early%0d got rv=%b need 0", i, bus.rsp_valid);
      end
      tick();
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_rdata, bus.mem_valid} !== {2'b11, 32'h0, 1'b0}) begin
      errors++; $display("FAIL tmo_rsp got rv=%b t=%b d=%h mv=%b need 1 1 0 0", bus.rsp_valid,
                         bus.rsp_timeout, bus.rsp_rdata, bus.mem_valid);
    end
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_byte();
    test_load_half();
    test_misaligned();
    test_stall();
    test_reset_mid_wait();
    test_back_to_back();
`ifdef RV32I_LSU_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
